// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle between two requesters and the shared ALU arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              req0_valid;
    logic              req0_ready;
    logic [2:0]        req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [2:0]        req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_res;
    logic              rsp0_zero;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_res;
    logic              rsp1_zero;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_res, rsp0_zero,
        input  rsp1_valid, rsp1_res, rsp1_zero
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_res, rsp0_zero,
        output rsp1_valid, rsp1_res, rsp1_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external 16-bit ALU between two requesters, one op in flight,
// with a shift-and-add multiply sequenced on the ALU adder when MUL_EN is set.
module alu_arbiter #(
    parameter bit MUL_EN = 1'b1,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_zero
);
    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [2:0]      OP_ADD   = 3'b000;
    localparam logic [2:0]      OP_MUL   = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

    state_t            state, state_nxt;
    logic              last_grant, owner, grant, accept, rsp_hs;
    logic [2:0]        sel_op, op_q;
    logic [DATA_W-1:0] sel_a, sel_b, a_q, b_q;
    logic [DATA_W-1:0] acc, mcand, mplr, res_q;
    logic              zero_q;
    logic [CNT_W-1:0]  cnt;

    function automatic logic [DATA_W-1:0] mul_addend(input logic [DATA_W-1:0] mc,
                                                     input logic bit0);
        return bit0 ? mc : '0;
    endfunction

    // Tie goes to whoever was not served last; a lone valid always wins.
    always_comb begin
        grant = ~last_grant;
        if (bus.req0_valid && !bus.req1_valid)
            grant = 1'b0;
        else if (bus.req1_valid && !bus.req0_valid)
            grant = 1'b1;
    end

    assign sel_op = grant ? bus.req1_op : bus.req0_op;
    assign sel_a  = grant ? bus.req1_a  : bus.req0_a;
    assign sel_b  = grant ? bus.req1_b  : bus.req0_b;
    assign accept = (state == IDLE) && (grant ? bus.req1_valid : bus.req0_valid);
    assign rsp_hs = (state == RESP) && (owner ? bus.rsp1_ready : bus.rsp0_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.rsp0_res   = '0;
        bus.rsp1_res   = '0;
        bus.rsp0_zero  = 1'b0;
        bus.rsp1_zero  = 1'b0;
        alu_op         = OP_ADD;
        alu_a          = '0;
        alu_b          = '0;
        case (state)
            IDLE: begin
                bus.req0_ready = rst_n && !grant && bus.req0_valid;
                bus.req1_ready = rst_n &&  grant && bus.req1_valid;
                if (accept)
                    state_nxt = (MUL_EN && sel_op == OP_MUL) ? MUL : EXEC;
            end
            EXEC: begin
                alu_op    = op_q;
                alu_a     = a_q;
                alu_b     = b_q;
                state_nxt = RESP;
            end
            MUL: begin
                alu_op = OP_ADD;
                alu_a  = acc;
                alu_b  = mul_addend(mcand, mplr[0]);
                if (cnt == CNT_LAST)
                    state_nxt = RESP;
            end
            RESP: begin
                bus.rsp0_valid = !owner;
                bus.rsp1_valid =  owner;
                bus.rsp0_res   = owner ? '0   : res_q;
                bus.rsp1_res   = owner ? res_q : '0;
                bus.rsp0_zero  = !owner && zero_q;
                bus.rsp1_zero  =  owner && zero_q;
                if (rsp_hs)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplr       <= '0;
            cnt        <= '0;
            res_q      <= '0;
            zero_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    owner <= grant;
                    op_q  <= sel_op;
                    a_q   <= sel_a;
                    b_q   <= sel_b;
                    acc   <= '0;
                    mcand <= sel_a;
                    mplr  <= sel_b;
                    cnt   <= '0;
                end
                EXEC: begin
                    res_q  <= alu_res;
                    zero_q <= alu_zero;
                end
                // Partial products accumulate through the ALU adder; bits above DATA_W fall off.
                MUL: begin
                    acc   <= alu_res;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        res_q  <= alu_res;
                        zero_q <= (alu_res == '0);
                    end
                end
                RESP: if (rsp_hs) last_grant <= owner;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: transaction-level reference, directed plus random traffic.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    alu_arbiter_if bus ();
    alu_arbiter_if bus2 ();

    logic [2:0]  alu_op, alu_op2;
    logic [15:0] alu_a, alu_b, alu_res, alu_a2, alu_b2, alu_res2;
    logic        alu_zero, alu_zero2;

    // External ALU: zero flag reports A==B.
    function automatic logic [16:0] alu_model(input logic [2:0] op, input logic [15:0] a, b);
        logic [15:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a << b[3:0];
            3'd3: r = a >> b[3:0];
            3'd4: r = $signed(a) >>> b[3:0];
            3'd5: r = ~(a & b);
            3'd6: r = a | b;
            default: r = a + b;
        endcase
        return {a == b, r};
    endfunction

    assign {alu_zero, alu_res}   = alu_model(alu_op, alu_a, alu_b);
    assign {alu_zero2, alu_res2} = alu_model(alu_op2, alu_a2, alu_b2);

    alu_arbiter #(.MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res), .alu_zero(alu_zero)
    );

    alu_arbiter #(.MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .alu_op(alu_op2), .alu_a(alu_a2), .alu_b(alu_b2),
        .alu_res(alu_res2), .alu_zero(alu_zero2)
    );

    typedef struct {
        logic [15:0] res;
        logic        zero;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   order_q[$];
    bit   busy = 1'b0;
    bit   ref_last = 1'b1;
    bit   pv0 = 1'b0, pv1 = 1'b0;
    logic [15:0] hold0 = '0, hold1 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, b, input int c);
        exp_t e;
        logic [31:0] p;
        logic [16:0] zr;
        if (op == 3'b111) begin
            p     = 32'(a) * 32'(b);
            e.res = p[15:0];
            e.zero = (p[15:0] == 16'd0);
            e.cyc = c + 17;
        end else begin
            zr     = alu_model(op, a, b);
            e.res  = zr[15:0];
            e.zero = zr[16];
            e.cyc  = c + 2;
        end
        return e;
    endfunction

    task automatic cmp_rsp(input int n, input exp_t e, input logic [15:0] res, input logic zero);
        chk($sformatf("rsp%0d_res", n), 32'(res), 32'(e.res));
        chk($sformatf("rsp%0d_zero", n), 32'(zero), 32'(e.zero));
        chk($sformatf("rsp%0d_latency", n), 32'(cyc), 32'(e.cyc));
    endtask

    task automatic monitor();
        bit v0, v1, r0, r1, g, n;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q0.delete();
                q1.delete();
                busy = 1'b0;
                ref_last = 1'b1;
                pv0 = 1'b0;
                pv1 = 1'b0;
            end else begin
                v0 = bus.req0_valid; v1 = bus.req1_valid;
                r0 = bus.req0_ready; r1 = bus.req1_ready;
                if (busy)
                    chk("ready_while_busy", 32'({r0, r1}), 32'd0);
                else if (v0 || v1) begin
                    g = (v0 && v1) ? ~ref_last : v1;
                    chk("grant", 32'({r0, r1}), 32'({~g, g}));
                end
                if ((v0 && r0) || (v1 && r1)) begin
                    n = v1 && r1;
                    if (n) begin
                        e = model(bus.req1_op, bus.req1_a, bus.req1_b, cyc);
                        q1.push_back(e);
                    end else begin
                        e = model(bus.req0_op, bus.req0_a, bus.req0_b, cyc);
                        q0.push_back(e);
                    end
                    order_q.push_back(int'(n));
                    busy = 1'b1;
                end
                if (bus.rsp0_valid || bus.rsp1_valid)
                    chk("rsp_exclusive", 32'(bus.rsp0_valid && bus.rsp1_valid), 32'd0);
                if (!bus.rsp0_valid)
                    chk("rsp0_idle_zero", 32'({bus.rsp0_res, bus.rsp0_zero}), 32'd0);
                else begin
                    if (!pv0) begin
                        if (q0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
                        else cmp_rsp(0, q0.pop_front(), bus.rsp0_res, bus.rsp0_zero);
                    end else
                        chk("rsp0_stable", 32'(bus.rsp0_res), 32'(hold0));
                    hold0 = bus.rsp0_res;
                    if (bus.rsp0_ready) begin ref_last = 1'b0; busy = 1'b0; end
                end
                if (!bus.rsp1_valid)
                    chk("rsp1_idle_zero", 32'({bus.rsp1_res, bus.rsp1_zero}), 32'd0);
                else begin
                    if (!pv1) begin
                        if (q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
                        else cmp_rsp(1, q1.pop_front(), bus.rsp1_res, bus.rsp1_zero);
                    end else
                        chk("rsp1_stable", 32'(bus.rsp1_res), 32'(hold1));
                    hold1 = bus.rsp1_res;
                    if (bus.rsp1_ready) begin ref_last = 1'b1; busy = 1'b0; end
                end
                pv0 = bus.rsp0_valid && !bus.rsp0_ready;
                pv1 = bus.rsp1_valid && !bus.rsp1_ready;
            end
        end
    endtask

    function automatic logic [15:0] rand_operand();
        case ($urandom_range(0, 3))
            0: return 16'($urandom_range(0, 20));
            1: return 16'hFFFF - 16'($urandom_range(0, 20));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic set_req(input int n, input logic v, input logic [2:0] op, input logic [15:0] a, b);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic issue(input int n, input logic [2:0] op, input logic [15:0] a, b);
        bit done = 1'b0;
        @(posedge clk); #1;
        set_req(n, 1'b1, op, a, b);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (n == 0) ? bus.req0_ready : bus.req1_ready;
        end
        if (!done) chk("issue_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (n == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = !busy && q0.size() == 0 && q1.size() == 0 && !bus.rsp0_valid && !bus.rsp1_valid;
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int start, accepted;
        bit a0, a1, done;
        fork
            monitor();
        join_none
        set_req(0, 1'b0, 3'd0, 16'd0, 16'd0);
        set_req(1, 1'b0, 3'd0, 16'd0, 16'd0);
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        bus2.req0_valid = 1'b0; bus2.req0_op = 3'd0; bus2.req0_a = '0; bus2.req0_b = '0;
        bus2.req1_valid = 1'b0; bus2.req1_op = 3'd0; bus2.req1_a = '0; bus2.req1_b = '0;
        bus2.rsp0_ready = 1'b1; bus2.rsp1_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
        chk("reset_req_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        chk("reset_rsp_res", 32'({bus.rsp0_res, bus.rsp1_res}), 32'd0);
        chk("reset_rsp_zero", 32'({bus.rsp0_zero, bus.rsp1_zero}), 32'd0);
        chk("reset_alu_drive", 32'({alu_op, alu_a, alu_b}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Tie with both valid held: strict alternation starting at req0.
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        start = order_q.size();
        set_req(0, 1'b1, 3'd1, 16'd7, 16'd7);
        set_req(1, 1'b1, 3'd6, 16'h00F0, 16'h000F);
        accepted = 0;
        for (int i = 0; i < 100 && accepted < 4; i++) begin
            @(negedge clk);
            if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready))
                accepted++;
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        chk("tie_accepts", 32'(accepted), 32'd4);
        if (order_q.size() >= start + 4)
            for (int k = 0; k < 4; k++)
                chk("tie_order", 32'(order_q[start + k]), 32'(k % 2));
        wait_idle();

        issue(0, 3'd0, 16'd5, 16'd3);
        wait_idle();
        issue(1, 3'd7, 16'd300, 16'd7);
        issue(1, 3'd7, 16'hFFFD, 16'd5);
        issue(1, 3'd7, 16'h0100, 16'h0100);
        wait_idle();

        // Backpressure on rsp0 while req1 waits.
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b0;
        issue(0, 3'd0, 16'h1234, 16'h0101);
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = bus.rsp0_valid;
        end
        chk("bp_rsp_seen", 32'(done), 32'd1);
        @(posedge clk); #1;
        set_req(1, 1'b1, 3'd2, 16'h0003, 16'd4);
        repeat (4) begin
            @(negedge clk);
            chk("bp_req1_held", 32'(bus.req1_ready), 32'd0);
            chk("bp_res_stable", 32'(bus.rsp0_res), 32'h1335);
        end
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        chk("bp_req1_in_resp", 32'(bus.req1_ready), 32'd0);
        @(negedge clk);
        chk("bp_req1_next", 32'(bus.req1_ready), 32'd1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        wait_idle();

        // Random traffic; a request only changes once taken or while not valid.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            @(posedge clk); #1;
            if (a0 || !bus.req0_valid)
                set_req(0, $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), rand_operand(), rand_operand());
            if (a1 || !bus.req1_valid)
                set_req(1, $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), rand_operand(), rand_operand());
            bus.rsp0_ready = $urandom_range(0, 3) != 0;
            bus.rsp1_ready = $urandom_range(0, 3) != 0;
        end
        @(negedge clk);
        a0 = bus.req0_valid && bus.req0_ready;
        a1 = bus.req1_valid && bus.req1_ready;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        wait_idle();

        // Reset in the middle of a multiply: everything drops, nothing is answered.
        issue(0, 3'd7, 16'd300, 16'h00FF);
        set_req(1, 1'b1, 3'd0, 16'd9, 16'd1);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
        chk("midrst_req_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        chk("midrst_rsp_res", 32'({bus.rsp0_res, bus.rsp1_res, bus.rsp0_zero, bus.rsp1_zero}), 32'd0);
        chk("midrst_alu_drive", 32'({alu_op, alu_a, alu_b}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        set_req(0, 1'b1, 3'd0, 16'd1, 16'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_tie", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = bus.req1_ready;
        end
        chk("postrst_req1_taken", 32'(done), 32'd1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        wait_idle();

        // Opcode 111 without the multiplier goes straight through the ALU.
        @(posedge clk); #1;
        bus2.req0_valid = 1'b1; bus2.req0_op = 3'b111; bus2.req0_a = 16'd2; bus2.req0_b = 16'd3;
        @(negedge clk);
        chk("nomul_accept", 32'(bus2.req0_ready), 32'd1);
        @(posedge clk); #1;
        bus2.req0_valid = 1'b0;
        @(negedge clk);
        chk("nomul_alu_op", 32'(alu_op2), 32'd7);
        chk("nomul_not_yet", 32'(bus2.rsp0_valid), 32'd0);
        @(negedge clk);
        chk("nomul_valid", 32'(bus2.rsp0_valid), 32'd1);
        chk("nomul_res", 32'(bus2.rsp0_res), 32'd5);
        chk("nomul_zero", 32'(bus2.rsp0_zero), 32'd0);
        chk("nomul_rsp1", 32'(bus2.rsp1_valid), 32'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 16-bit ALU datapath between two requesters (e.g. the execute stage and a background address/shift unit) with valid/ready handshakes on both request and response sides. Arbitration is round-robin, and one operation is in flight at a time. The block also sequences a multi-cycle 16×16 multiply (low 16 bits) on the ALU using repeated ALU adds. It sits between the requesters and the external ALU instance, whose ports it drives.

## Interface
- `MUL_EN`, default 1: when 1, opcode 3'b111 is a multi-cycle multiply. When 0, 3'b111 passes to the ALU as a single-cycle op.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid`, `req1_valid`  in  1  requester N has an operation.
- `req0_ready`, `req1_ready`  out  1  operation N accepted this cycle when valid&ready.
- `req0_op`, `req1_op`  in  3  ALU opcode: 000 add, 001 sub, 010 shl, 011 shr, 100 sra, 101 nand, 110 or, 111 mul/default.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  16  operands (two's complement).
- `rsp0_valid`, `rsp1_valid`  out  1  result for requester N available.
- `rsp0_ready`, `rsp1_ready`  in  1  requester N takes the result.
- `rsp0_res`, `rsp1_res`  out  16  result.
- `rsp0_zero`, `rsp1_zero`  out  1  single-cycle ops: ALU zero flag (A==B). mul: product==0.
- `alu_op`  out  3  to ALU opcode.
- `alu_a`, `alu_b`  out  16  to ALU operands.
- `alu_res`  in  16  from ALU result.
- `alu_zero`  in  1  from ALU zero flag.

## Operation
States:
- **IDLE:** no operation in flight.
  - `reqN_ready = (state==IDLE) && grant==N && reqN_valid`; grant is combinational.
  - Arbitration: only one valid → that one is granted. Both valid → the requester not equal to `last_grant` is granted.
  - `last_grant` resets to 1, so req0 wins the first tie.
  - On handshake: latch op, a, b and owner. Go to MUL if `MUL_EN && op==111`, else EXEC.
- **EXEC** (1 cycle):
  - Drive `alu_op`/`alu_a`/`alu_b` from the latched registers.
  - Latch `alu_res` into `res_q` and `alu_zero` into `zero_q`.
  - Go to RESP.
- **MUL** (exactly 16 cycles, counter 0..15; no early exit):
  - `alu_op=000`, `alu_a=acc`, `alu_b = mplr[0] ? mcand : 0`.
  - Each cycle: `acc<=alu_res`, `mcand<=mcand<<1` (local), `mplr<=mplr>>1` (logical).
  - On entry: `acc=0`, `mcand=a`, `mplr=b`.
  - After count 15: `res_q` = final `acc` (final add included), `zero_q = (res_q==0)`. Go to RESP.
  - The low 16 bits are identical for signed and unsigned operands; overflow is discarded.
- **RESP:**
  - `rspN_valid=1` for the owner only; `res`/`zero` are held stable until `rspN_ready`.
  - On handshake: `last_grant<=owner`, go to IDLE.
  - No request is accepted while in RESP.
- **ALU drive:** outside EXEC/MUL, drive `alu_op=000`, `alu_a=0`, `alu_b=0`.
- **Operands:** passed unmodified; signedness is interpreted by the ALU.
- **Unused rsp outputs:** `rsp_res`/`rsp_zero` of the non-owner read 0. The owner's outputs show `res_q`/`zero_q` only while valid, and 0 otherwise.
- **Reset** (async, any state, including mid-MUL): state IDLE; `last_grant` 1; `acc`, `mcand`, `mplr`, count, `res_q`, `zero_q` 0. The in-flight operation is dropped with no response.

## Timing
- **Reset values:** all `req*_ready`, `rsp*_valid`, `rsp*_res`, `rsp*_zero` are 0. `alu_op` is 000 and `alu_a`/`alu_b` are 0.
- **Single-cycle op:**
  - Accept in cycle 0, EXEC in cycle 1, `rsp_valid` from cycle 2.
  - If `rsp_ready` is high in cycle 2, IDLE in cycle 3, and a new accept is possible in cycle 3.
  - Best-case throughput is 1 op per 3 cycles.
- **MUL:** accept in cycle 0, MUL in cycles 1–16, `rsp_valid` from cycle 17.
- **Ready dependency:** `req_ready` depends combinationally on `req_valid` (both valids, for the tie). `req_valid` must not depend on `req_ready`.
- **Simultaneous rsp_ready with a new req_valid:** the new request is granted in the next cycle (IDLE), using the updated `last_grant`.
- **Opcode 111 with `MUL_EN=0`:** EXEC; the ALU default (add) result is returned after 1 cycle.

## Test plan
- **Single add:** req0 add, a=5, b=3, `rsp0_ready=1` → `req0_ready` in cycle 0; `rsp0_valid` in cycle 2 with res=8, zero=0; `rsp1_valid` stays 0.
- **Tie and rotation:** both valid continuously, req0 sub 7−7, req1 or 0x00F0|0x000F → order req0, req1, req0, req1. req0 returns res=0 with zero=1; req1 returns res=0x00FF with zero=0.
- **Multiply:** req1 mul 300×7 → `rsp1_valid` in cycle 17, res=2100. Mul 0xFFFD×5 → res=0xFFF1, zero=0. Mul 0x0100×0x0100 → res=0, zero=1.
- **Backpressure:** `rsp0_ready` low for 4 cycles while req1 is valid → `rsp0_res` is stable, `req1_ready` stays 0. After `rsp0_ready`, req1 is accepted one cycle later.
- **Reset mid-operation:** assert `rst_n` low in MUL cycle 8 → all outputs 0 asynchronously; no response follows. After release, a tie is granted to req0.
- **`MUL_EN=0`:** op 111 with a=2, b=3 → res=5 in cycle 2.
